// File: rtl/branch_pkg.sv
// Shared definitions for the branch sequencing controller.
// Contents:
//   OPC_BRANCH            - B-type major opcode (1100011)
//   F3_*                  - funct3 codes for the six conditional branches
//   RF_TIMEOUT_DEFAULT    - default READ-state wait limit for rf_ack
//   state_t               - controller FSM state encoding
//   is_legal_branch()     - opcode/funct3 legality test used in DECODE
package branch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int RF_TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // funct3 values 010 and 011 are unused in the branch opcode space
  function automatic logic is_legal_branch(input logic [6:0] opcode,
                                           input logic [2:0] funct3);
    return (opcode == OPC_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);
  endfunction

endpackage

// File: rtl/b_field_imm.sv
// Combinational field splitter and B-type immediate assembler.
// Ports:
//   instr_word - 32-bit instruction word (in)
//   rs1, rs2   - source register indices (out)
//   funct3     - branch condition selector (out)
//   opcode     - major opcode (out)
//   imm        - sign-extended byte offset, bit 0 always zero (out)
module b_field_imm (
  input  logic [31:0] instr_word,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  opcode,
  output logic [31:0] imm
);

  assign rs2    = instr_word[24:20];
  assign rs1    = instr_word[19:15];
  assign funct3 = instr_word[14:12];
  assign opcode = instr_word[6:0];

  // The 13-bit offset is scattered across the imm_B_MSB/imm_B_LSB fields;
  // bit 12 (instr[31]) is replicated for the sign extension.
  assign imm = {{19{instr_word[31]}}, instr_word[31], instr_word[7],
                instr_word[30:25], instr_word[11:8], 1'b0};

endmodule

// File: rtl/branch_seq_ctrl.sv
// Multi-cycle branch resolution controller.
// Accepts one B-type instruction at a time, reads its two operands from a
// handshaked register file, evaluates the branch and presents the result
// until the consumer takes it.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   in_valid/in_ready          - instruction handshake (ready only in IDLE)
//   instr_word, pc             - instruction and its address
//   rf_req, rf_rs1, rf_rs2     - register-file read request and indices
//   rf_ack, rf_rdata1/2        - register-file response
//   out_valid/out_ready        - result handshake
//   taken, next_pc             - branch outcome
//   illegal, misaligned,
//   rf_timeout                 - mutually exclusive error flags
module branch_seq_ctrl
  import branch_pkg::*;
#(
  parameter int RF_TIMEOUT = RF_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr_word,
  input  logic [31:0] pc,
  output logic        rf_req,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  input  logic        rf_ack,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        taken,
  output logic [31:0] next_pc,
  output logic        illegal,
  output logic        misaligned,
  output logic        rf_timeout
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(RF_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        taken_q, taken_d;
  logic        illegal_q, illegal_d;
  logic        mis_q, mis_d;
  logic        timeout_q, timeout_d;

  logic [4:0]  f_rs1, f_rs2;
  logic [2:0]  f_funct3;
  logic [6:0]  f_opcode;
  logic [31:0] f_imm;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        cond;

  b_field_imm u_field (
    .instr_word (instr_q),
    .rs1        (f_rs1),
    .rs2        (f_rs2),
    .funct3     (f_funct3),
    .opcode     (f_opcode),
    .imm        (f_imm)
  );

  assign pc_plus4 = pc_q + 32'd4;
  assign target   = pc_q + f_imm;

  // Branch condition on the latched operands; only meaningful in EXEC,
  // where funct3 is already known to be one of the six legal codes.
  always_comb begin
    cond = 1'b0;
    case (f_funct3)
      F3_BEQ:  cond = (op1_q == op2_q);
      F3_BNE:  cond = (op1_q != op2_q);
      F3_BLT:  cond = ($signed(op1_q) <  $signed(op2_q));
      F3_BGE:  cond = ($signed(op1_q) >= $signed(op2_q));
      F3_BLTU: cond = (op1_q <  op2_q);
      F3_BGEU: cond = (op1_q >= op2_q);
      default: cond = 1'b0;
    endcase
  end

  // Next-state and datapath updates. Result registers are only written on
  // acceptance (cleared) and on the single transition into DONE, so they
  // stay stable for the whole DONE hold.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    next_pc_d = next_pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    cnt_d     = cnt_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    mis_d     = mis_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          instr_d   = instr_word;
          pc_d      = pc;
          next_pc_d = '0;
          taken_d   = 1'b0;
          illegal_d = 1'b0;
          mis_d     = 1'b0;
          timeout_d = 1'b0;
          state_d   = DECODE;
        end
      end

      DECODE: begin
        rs1_d = f_rs1;
        rs2_d = f_rs2;
        if (!is_legal_branch(f_opcode, f_funct3)) begin
          illegal_d = 1'b1;
          next_pc_d = pc_plus4;
          state_d   = DONE;
        end else begin
          cnt_d   = 8'd1;
          state_d = READ;
        end
      end

      // cnt_q holds the number of the current READ cycle; an ack on the
      // last permitted cycle still wins over the timeout.
      READ: begin
        if (rf_ack) begin
          op1_d   = rf_rdata1;
          op2_d   = rf_rdata2;
          cnt_d   = '0;
          state_d = EXEC;
        end else if (cnt_q >= TIMEOUT_CNT) begin
          timeout_d = 1'b1;
          next_pc_d = pc_plus4;
          cnt_d     = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // A taken branch to a non-word-aligned target is suppressed and
      // reported instead of redirecting the fetch.
      EXEC: begin
        if (cond && (target[1:0] != 2'b00)) begin
          mis_d     = 1'b1;
          taken_d   = 1'b0;
          next_pc_d = pc_plus4;
        end else begin
          taken_d   = cond;
          next_pc_d = cond ? target : pc_plus4;
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; an in-flight instruction is
  // simply discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      pc_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      next_pc_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      cnt_q     <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      mis_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      next_pc_q <= next_pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      cnt_q     <= cnt_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      mis_q     <= mis_d;
      timeout_q <= timeout_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign rf_req     = (state_q == READ);
  assign out_valid  = (state_q == DONE);
  assign rf_rs1     = rs1_q;
  assign rf_rs2     = rs2_q;
  assign taken      = taken_q;
  assign next_pc    = next_pc_q;
  assign illegal    = illegal_q;
  assign misaligned = mis_q;
  assign rf_timeout = timeout_q;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Self-checking bench for branch_seq_ctrl.
// Directed transactions are driven one at a time; a behavioural model
// predicts each result, and a single compare process checks the DUT
// against it on every cycle the result is presented.
module tb_branch_seq_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_word;
  logic [31:0] pc;
  logic        rf_req;
  logic [4:0]  rf_rs1;
  logic [4:0]  rf_rs2;
  logic        rf_ack;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [31:0] next_pc;
  logic        illegal;
  logic        misaligned;
  logic        rf_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
    logic        timeout;
    logic        taken;
    logic        mis;
    logic [31:0] nextPc;
    int          lat;
    int          req;
  } model_t;

  model_t expR;
  logic   expArmed = 1'b0;

  logic        capTaken, capIllegal, capMis, capTimeout;
  logic [31:0] capNextPc;
  logic [4:0]  capRs1, capRs2;

  branch_seq_ctrl #(.RF_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr_word (instr_word),
    .pc         (pc),
    .rf_req     (rf_req),
    .rf_rs1     (rf_rs1),
    .rf_rs2     (rf_rs2),
    .rf_ack     (rf_ack),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .taken      (taken),
    .next_pc    (next_pc),
    .illegal    (illegal),
    .misaligned (misaligned),
    .rf_timeout (rf_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Result predicted from the instruction semantics. ackAt is the READ
  // cycle (1-based) on which the register file answers, 0 for never.
  // Latency is counted in rising edges, the acceptance edge being the first.
  function automatic model_t predict(input logic [31:0] instr,
                                     input logic [31:0] pcv,
                                     input logic [31:0] d1,
                                     input logic [31:0] d2,
                                     input int ackAt);
    model_t m;
    int unsigned opc, f3;
    int imm;
    logic c;
    logic [31:0] tgt;
    opc = instr & 32'h7f;
    f3  = (instr >> 12) & 7;
    m.rs1     = 5'((instr >> 15) & 31);
    m.rs2     = 5'((instr >> 20) & 31);
    m.illegal = 1'b0;
    m.timeout = 1'b0;
    m.taken   = 1'b0;
    m.mis     = 1'b0;
    m.nextPc  = pcv + 32'd4;
    if (opc != 32'h63 || f3 == 2 || f3 == 3) begin
      m.illegal = 1'b1;
      m.lat = 2;
      m.req = 0;
    end else if (ackAt == 0 || ackAt > TMO) begin
      m.timeout = 1'b1;
      m.lat = 2 + TMO;
      m.req = TMO;
    end else begin
      imm = 0;
      if (((instr >> 31) & 1) != 0) imm -= 4096;
      imm += int'((instr >> 7) & 1) * 2048;
      imm += int'((instr >> 25) & 63) * 32;
      imm += int'((instr >> 8) & 15) * 2;
      case (f3)
        0: c = (d1 == d2);
        1: c = (d1 != d2);
        4: c = ($signed(d1) < $signed(d2));
        5: c = ($signed(d1) >= $signed(d2));
        6: c = (d1 < d2);
        default: c = (d1 >= d2);
      endcase
      tgt = pcv + 32'(imm);
      if (c && (tgt % 4) != 0) m.mis = 1'b1;
      else if (c) begin
        m.taken  = 1'b1;
        m.nextPc = tgt;
      end
      m.lat = 3 + ackAt;
      m.req = ackAt;
    end
    return m;
  endfunction

  // Every presented result is compared with the model each cycle it is
  // held, so any drift during backpressure shows up as well.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (!expArmed) begin
          checkOutput("spurious_out_valid", out_valid, 1'b0);
        end else begin
          checkOutput("taken", taken, expR.taken);
          checkOutput("next_pc", next_pc, expR.nextPc);
          checkOutput("illegal", illegal, expR.illegal);
          checkOutput("misaligned", misaligned, expR.mis);
          checkOutput("rf_timeout", rf_timeout, expR.timeout);
          checkOutput("in_ready_in_done", in_ready, 1'b0);
        end
      end
      if (rf_req && expArmed) begin
        checkOutput("rf_rs1", rf_rs1, expR.rs1);
        checkOutput("rf_rs2", rf_rs2, expR.rs2);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pcv,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input int ackAt, input int readyHold);
    int edges;
    int reqCycles;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("in_ready_wait", in_ready, 1'b1);
    expR       = predict(instr, pcv, d1, d2, ackAt);
    expArmed   = 1'b1;
    in_valid   = 1'b1;
    instr_word = instr;
    pc         = pcv;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    rf_ack    = 1'b0;
    edges     = 1;
    reqCycles = 0;
    while (!out_valid && edges < 60) begin
      if (rf_req) begin
        reqCycles++;
        capRs1    = rf_rs1;
        capRs2    = rf_rs2;
        rf_ack    = (reqCycles == ackAt);
        rf_rdata1 = d1;
        rf_rdata2 = d2;
      end else begin
        rf_ack = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    rf_ack = 1'b0;
    checkOutput("out_valid_arrives", out_valid, 1'b1);
    checkOutput("latency", edges, expR.lat);
    checkOutput("rf_req_cycles", reqCycles, expR.req);
    capTaken   = taken;
    capNextPc  = next_pc;
    capIllegal = illegal;
    capMis     = misaligned;
    capTimeout = rf_timeout;
    repeat (readyHold) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    expArmed  = 1'b0;
    checkOutput("out_valid_after_handshake", out_valid, 1'b0);
    checkOutput("in_ready_after_handshake", in_ready, 1'b1);
  endtask

  task automatic checkAllClear(input string tag);
    checkOutput({tag, "_out_valid"}, out_valid, 1'b0);
    checkOutput({tag, "_rf_req"}, rf_req, 1'b0);
    checkOutput({tag, "_taken"}, taken, 1'b0);
    checkOutput({tag, "_flags"}, {illegal, misaligned, rf_timeout}, 3'b000);
    checkOutput({tag, "_next_pc"}, next_pc, 32'h0);
    checkOutput({tag, "_rs"}, {rf_rs1, rf_rs2}, 10'h0);
    checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    instr_word = '0;
    pc         = '0;
    rf_ack     = 1'b0;
    rf_rdata1  = '0;
    rf_rdata2  = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllClear("reset");
    @(negedge clk);
    rst = 1'b0;

    // BEQ taken, register file answers in the first READ cycle
    applyStimulus(32'h00208463, 32'h100, 32'd5, 32'd5, 1, 0);
    checkOutput("beq_lit_taken", capTaken, 1'b1);
    checkOutput("beq_lit_next_pc", capNextPc, 32'h108);
    checkOutput("beq_lit_rs", {capRs1, capRs2}, {5'd1, 5'd2});

    // BLT taken backwards vs BLTU not taken on the same operands
    applyStimulus(32'hFE41CEE3, 32'h200, 32'hFFFFFFFF, 32'd1, 1, 0);
    checkOutput("blt_lit_next_pc", capNextPc, 32'h1FC);
    applyStimulus(32'hFE41EEE3, 32'h200, 32'hFFFFFFFF, 32'd1, 1, 0);
    checkOutput("bltu_lit", {31'(capNextPc), capTaken}, {31'(32'h204), 1'b0});

    // Remaining conditions, including late acks
    applyStimulus(32'h00209463, 32'h300, 32'd7, 32'd5, 3, 0);
    applyStimulus(32'h00209463, 32'h300, 32'd7, 32'd7, 2, 0);
    applyStimulus(32'h0020D463, 32'h400, 32'h80000000, 32'd1, 1, 0);
    applyStimulus(32'h0020D463, 32'h400, 32'd9, 32'd9, 1, 0);
    applyStimulus(32'h0020F463, 32'h500, 32'd1, 32'hFFFFFFFF, 1, 0);
    applyStimulus(32'h0020F463, 32'h500, 32'hFFFFFFFF, 32'd1, 1, 0);

    // Illegal encodings never touch the register file
    applyStimulus(32'h0020A463, 32'h600, 32'd0, 32'd0, 1, 0);
    checkOutput("illegal_lit", {capIllegal, capNextPc}, {1'b1, 32'h604});
    applyStimulus(32'h00208433, 32'h700, 32'd0, 32'd0, 1, 0);

    // Timeout and the last-cycle ack boundary
    applyStimulus(32'h00208463, 32'h800, 32'd1, 32'd1, 0, 0);
    checkOutput("timeout_lit", {capTimeout, capNextPc}, {1'b1, 32'h804});
    applyStimulus(32'h00208463, 32'h900, 32'd1, 32'd1, TMO, 0);

    // Misaligned target with 3 cycles of backpressure
    applyStimulus(32'h00208363, 32'hA00, 32'd3, 32'd3, 1, 3);
    checkOutput("mis_lit", {capMis, capTaken}, {1'b1, 1'b0});

    // Target wrap-around past 2^32
    applyStimulus(32'h00208463, 32'hFFFFFFFC, 32'd2, 32'd2, 1, 0);
    checkOutput("wrap_lit_next_pc", capNextPc, 32'h4);

    // Reset while waiting in READ drops the instruction
    @(negedge clk);
    in_valid   = 1'b1;
    instr_word = 32'h00208463;
    pc         = 32'hB00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_reset_rf_req", rf_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkAllClear("mid_read_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("dropped_no_rf_req", rf_req, 1'b0);
    applyStimulus(32'h00208463, 32'h100, 32'd5, 32'd5, 1, 0);
    checkOutput("post_reset_beq", capNextPc, 32'h108);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
